// File: rtl/pc_fetch.sv
// -----------------------------------------------------------------------------
// pc_fetch
//   Program-counter and instruction-fetch controller feeding the IF stage.
//   Owns the PC and assembles each 32-bit little-endian instruction from four
//   byte reads over a shared 8-bit memory port. The finished instruction is
//   presented with pc_done=1 and held while the downstream stage stalls.
//   Branch/jump redirects from EX override everything except reset.
//
// Parameters
//   RESET_PC   PC loaded on reset (low two bits are ignored)
//
// Ports
//   clk        in   1   clock, rising edge
//   rst        in   1   synchronous active-high reset, highest priority
//   stall_in   in   1   downstream stall, holds the presented instruction
//   br_en      in   1   single-cycle redirect request
//   br_target  in   32  redirect address, bits [1:0] ignored
//   mem_grant  in   1   arbiter accepts this cycle's request
//   mem_rdata  in   8   read byte, valid the cycle after its grant
//   mem_req    out  1   byte read request
//   mem_addr   out  32  byte address = pc + issue index
//   pc_o       out  32  PC of the presented instruction
//   inst_o     out  32  assembled instruction (zero unless pc_done)
//   pc_done    out  1   pc_o/inst_o valid
// -----------------------------------------------------------------------------
module pc_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_in,
    input  logic        br_en,
    input  logic [31:0] br_target,
    input  logic        mem_grant,
    input  logic [7:0]  mem_rdata,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        pc_done
);

    localparam logic [31:0] RESET_PC_AL = {RESET_PC[31:2], 2'b00};

    typedef enum logic [0:0] {
        ST_FETCH = 1'b0,
        ST_DONE  = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [2:0]  r_issue_idx;
    logic [2:0]  w_issue_idx_nxt;
    logic [1:0]  r_recv_idx;
    logic [1:0]  w_recv_idx_nxt;
    logic        r_pend;
    logic        w_pend_nxt;
    logic [31:0] r_inst_buf;
    logic [31:0] w_inst_buf_nxt;
    logic        w_issue;
    logic        w_capture;

    // Request/capture qualifiers and the externally visible outputs
    always_comb begin
        // A request is only raised while bytes remain to be issued and no
        // redirect or reset is pending in the same cycle.
        w_issue   = (r_state == ST_FETCH) && (r_issue_idx < 3'd4) && !br_en && !rst;
        // r_pend marks a byte granted last cycle; its data is on mem_rdata now.
        w_capture = r_pend && !br_en && !rst;

        mem_req   = w_issue;
        mem_addr  = r_pc + {29'd0, r_issue_idx};
        pc_done   = (r_state == ST_DONE) && !rst;
        if (rst) begin
            pc_o = RESET_PC_AL;
        end else begin
            pc_o = r_pc;
        end
        if (pc_done) begin
            inst_o = r_inst_buf;
        end else begin
            inst_o = 32'd0;
        end
    end

    // Next-state logic: redirect first, then per-state progress
    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_issue_idx_nxt = r_issue_idx;
        w_recv_idx_nxt  = r_recv_idx;
        w_inst_buf_nxt  = r_inst_buf;
        w_pend_nxt      = w_issue && mem_grant;

        if (br_en) begin
            // Redirect also drops whatever byte is arriving this cycle.
            w_pc_nxt        = {br_target[31:2], 2'b00};
            w_state_nxt     = ST_FETCH;
            w_issue_idx_nxt = 3'd0;
            w_recv_idx_nxt  = 2'd0;
            w_pend_nxt      = 1'b0;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (w_issue && mem_grant) begin
                        w_issue_idx_nxt = r_issue_idx + 3'd1;
                    end else begin
                        w_issue_idx_nxt = r_issue_idx;
                    end
                    if (w_capture) begin
                        w_inst_buf_nxt[{r_recv_idx, 3'b000} +: 8] = mem_rdata;
                        if (r_recv_idx == 2'd3) begin
                            w_state_nxt    = ST_DONE;
                            w_recv_idx_nxt = 2'd0;
                        end else begin
                            w_recv_idx_nxt = r_recv_idx + 2'd1;
                        end
                    end else begin
                        w_recv_idx_nxt = r_recv_idx;
                    end
                end
                ST_DONE: begin
                    if (!stall_in) begin
                        w_pc_nxt        = r_pc + 32'd4;
                        w_state_nxt     = ST_FETCH;
                        w_issue_idx_nxt = 3'd0;
                        w_recv_idx_nxt  = 2'd0;
                    end else begin
                        w_state_nxt = ST_DONE;
                    end
                end
                default: begin
                    w_state_nxt     = ST_FETCH;
                    w_issue_idx_nxt = 3'd0;
                    w_recv_idx_nxt  = 2'd0;
                    w_pend_nxt      = 1'b0;
                end
            endcase
        end
    end

    // State registers; reset discards any partially assembled instruction
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_FETCH;
            r_pc        <= RESET_PC_AL;
            r_issue_idx <= 3'd0;
            r_recv_idx  <= 2'd0;
            r_pend      <= 1'b0;
            r_inst_buf  <= 32'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_issue_idx <= w_issue_idx_nxt;
            r_recv_idx  <= w_recv_idx_nxt;
            r_pend      <= w_pend_nxt;
            r_inst_buf  <= w_inst_buf_nxt;
        end
    end

endmodule

// File: tb/tb_pc_fetch.sv
// -----------------------------------------------------------------------------
// tb_pc_fetch
//   Self-checking bench for pc_fetch: a directed vector table, hand-written
//   multi-cycle corner sequences and a randomized phase, all cross-checked every
//   cycle against a transaction-level model (PC, bytes issued/received, done).
// -----------------------------------------------------------------------------
module tb_pc_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        stall_in;
    logic        br_en;
    logic [31:0] br_target;
    logic        mem_grant;
    logic [7:0]  mem_rdata;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        pc_done;

    pc_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk       (clk),
        .rst       (rst),
        .stall_in  (stall_in),
        .br_en     (br_en),
        .br_target (br_target),
        .mem_grant (mem_grant),
        .mem_rdata (mem_rdata),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .pc_o      (pc_o),
        .inst_o    (inst_o),
        .pc_done   (pc_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // transaction-level model state
    logic [31:0] m_pc;
    int          m_issued;
    int          m_recv;
    bit          m_done;
    bit          m_pend;
    // memory responder state
    bit          prev_g;
    logic [31:0] prev_a;
    // outputs sampled in the last step
    logic        o_req;
    logic [31:0] o_addr;
    logic [31:0] o_pc;
    logic [31:0] o_inst;
    logic        o_done;

    typedef struct {
        bit          r;
        bit          s;
        bit          b;
        logic [31:0] tgt;
        bit          g;
        bit          e_req;
        bit          c_addr;
        logic [31:0] e_addr;
        bit          e_done;
        bit          c_pc;
        logic [31:0] e_pc;
        bit          c_inst;
        logic [31:0] e_inst;
    } vec_t;

    vec_t vecs[$];

    // Memory image: the test program at 0..3, a hash everywhere else.
    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        logic [31:0] h;
        case (a)
            32'd0:   return 8'h13;
            32'd1:   return 8'h05;
            32'd2:   return 8'ha0;
            32'd3:   return 8'h00;
            default: begin
                h = a * 32'h9E37_79B1;
                return h[31:24] ^ a[7:0];
            end
        endcase
    endfunction

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {mem_byte(a + 32'd3), mem_byte(a + 32'd2), mem_byte(a + 32'd1), mem_byte(a)};
    endfunction

    function automatic vec_t mk(input bit r, s, b, input logic [31:0] tgt, input bit g,
                                input bit e_req, c_addr, input logic [31:0] e_addr,
                                input bit e_done, c_pc, input logic [31:0] e_pc,
                                input bit c_inst, input logic [31:0] e_inst);
        vec_t v;
        v.r = r; v.s = s; v.b = b; v.tgt = tgt; v.g = g;
        v.e_req = e_req; v.c_addr = c_addr; v.e_addr = e_addr;
        v.e_done = e_done; v.c_pc = c_pc; v.e_pc = e_pc;
        v.c_inst = c_inst; v.e_inst = e_inst;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs, compare against the model, advance the model.
    task automatic step(input bit r, input bit s, input bit b, input logic [31:0] t, input bit g);
        bit          e_req;
        bit          e_done;
        bit          new_pend;
        logic [31:0] e_addr;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        rst       = r;
        stall_in  = s;
        br_en     = b;
        br_target = t;
        mem_grant = g;
        mem_rdata = prev_g ? mem_byte(prev_a) : 8'($urandom);
        #1;
        o_req  = mem_req;
        o_addr = mem_addr;
        o_pc   = pc_o;
        o_inst = inst_o;
        o_done = pc_done;

        e_req  = !r && !b && !m_done && (m_issued < 4);
        e_addr = m_pc + 32'(m_issued);
        e_done = !r && m_done;
        e_pc   = r ? RESET_PC : m_pc;
        e_inst = e_done ? word_at(m_pc) : 32'd0;
        chk("model_req", 32'(mem_req), 32'(e_req));
        if (e_req) chk("model_addr", mem_addr, e_addr);
        chk("model_done", 32'(pc_done), 32'(e_done));
        chk("model_pc", pc_o, e_pc);
        chk("model_inst", inst_o, e_inst);

        prev_g = mem_req && g;
        prev_a = mem_addr;

        if (r) begin
            m_pc = RESET_PC; m_done = 0; m_issued = 0; m_recv = 0; m_pend = 0;
        end else if (b) begin
            m_pc = t & ~32'd3; m_done = 0; m_issued = 0; m_recv = 0; m_pend = 0;
        end else if (m_done) begin
            if (!s) begin
                m_pc = m_pc + 32'd4; m_done = 0; m_issued = 0; m_recv = 0;
            end
        end else begin
            new_pend = e_req && g;
            if (m_pend) begin
                m_recv++;
                if (m_recv == 4) m_done = 1;
            end
            if (new_pend) m_issued++;
            m_pend = new_pend;
        end
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] exp_w;
        logic [31:0] tgt;
        prev_g = 0; prev_a = 32'd0;
        m_pc = RESET_PC; m_done = 0; m_issued = 0; m_recv = 0; m_pend = 0;
        rst = 1'b1; stall_in = 1'b0; br_en = 1'b0; br_target = 32'd0;
        mem_grant = 1'b0; mem_rdata = 8'd0;

        // Reset, first fetch with grant always 1, then a 3-cycle stall.
        //            r  s  b  tgt    g  req ca addr    dn cp pc     ci inst
        vecs.push_back(mk(1, 0, 0, 32'd0, 1, 0, 0, 32'd0, 0, 1, 32'd0, 1, 32'd0));
        vecs.push_back(mk(0, 0, 0, 32'd0, 1, 1, 1, 32'd0, 0, 1, 32'd0, 1, 32'd0));
        vecs.push_back(mk(0, 0, 0, 32'd0, 1, 1, 1, 32'd1, 0, 0, 32'd0, 1, 32'd0));
        vecs.push_back(mk(0, 0, 0, 32'd0, 1, 1, 1, 32'd2, 0, 0, 32'd0, 1, 32'd0));
        vecs.push_back(mk(0, 0, 0, 32'd0, 1, 1, 1, 32'd3, 0, 0, 32'd0, 1, 32'd0));
        vecs.push_back(mk(0, 0, 0, 32'd0, 1, 0, 0, 32'd0, 0, 0, 32'd0, 1, 32'd0));
        vecs.push_back(mk(0, 1, 0, 32'd0, 1, 0, 0, 32'd0, 1, 1, 32'd0, 1, 32'h00a00513));
        vecs.push_back(mk(0, 1, 0, 32'd0, 1, 0, 0, 32'd0, 1, 1, 32'd0, 1, 32'h00a00513));
        vecs.push_back(mk(0, 1, 0, 32'd0, 1, 0, 0, 32'd0, 1, 1, 32'd0, 1, 32'h00a00513));
        vecs.push_back(mk(0, 0, 0, 32'd0, 1, 0, 0, 32'd0, 1, 1, 32'd0, 1, 32'h00a00513));
        vecs.push_back(mk(0, 0, 0, 32'd0, 1, 1, 1, 32'd4, 0, 1, 32'd4, 1, 32'd0));
        vecs.push_back(mk(0, 0, 0, 32'd0, 1, 1, 1, 32'd5, 0, 1, 32'd4, 1, 32'd0));

        foreach (vecs[i]) begin
            step(vecs[i].r, vecs[i].s, vecs[i].b, vecs[i].tgt, vecs[i].g);
            chk($sformatf("vec%0d_req", i), 32'(o_req), 32'(vecs[i].e_req));
            if (vecs[i].c_addr) chk($sformatf("vec%0d_addr", i), o_addr, vecs[i].e_addr);
            chk($sformatf("vec%0d_done", i), 32'(o_done), 32'(vecs[i].e_done));
            if (vecs[i].c_pc) chk($sformatf("vec%0d_pc", i), o_pc, vecs[i].e_pc);
            if (vecs[i].c_inst) chk($sformatf("vec%0d_inst", i), o_inst, vecs[i].e_inst);
        end

        // Grant withheld for two cycles after byte 1: address holds, done slips by 2.
        step(1, 0, 0, 32'd0, 1);
        step(0, 0, 0, 32'd0, 1);
        step(0, 0, 0, 32'd0, 1);
        step(0, 0, 0, 32'd0, 0); chk("nogrant_addr_a", o_addr, 32'd2); chk("nogrant_req", 32'(o_req), 32'd1);
        step(0, 0, 0, 32'd0, 0); chk("nogrant_addr_b", o_addr, 32'd2);
        step(0, 0, 0, 32'd0, 1); chk("nogrant_addr_c", o_addr, 32'd2);
        step(0, 0, 0, 32'd0, 1); chk("nogrant_addr_d", o_addr, 32'd3);
        step(0, 0, 0, 32'd0, 1); chk("nogrant_early_done", 32'(o_done), 32'd0);
        step(0, 1, 0, 32'd0, 1); chk("nogrant_done", 32'(o_done), 32'd1);
        chk("nogrant_inst", o_inst, 32'h00a00513);

        // Redirect to 0x103 after two bytes received.
        step(1, 0, 0, 32'd0, 1);
        step(0, 0, 0, 32'd0, 1);
        step(0, 0, 0, 32'd0, 1);
        step(0, 0, 0, 32'd0, 1);
        step(0, 0, 1, 32'h103, 1); chk("br_req_low", 32'(o_req), 32'd0);
        step(0, 0, 0, 32'd0, 1);
        chk("br_addr", o_addr, 32'h100); chk("br_pc", o_pc, 32'h100); chk("br_done", 32'(o_done), 32'd0);
        step(0, 0, 0, 32'd0, 1);
        step(0, 0, 0, 32'd0, 1);
        step(0, 0, 0, 32'd0, 1);
        step(0, 0, 0, 32'd0, 1);
        step(0, 1, 0, 32'd0, 1);
        exp_w = word_at(32'h100);
        chk("br_fetch_done", 32'(o_done), 32'd1);
        chk("br_inst", o_inst, exp_w);
        chk("br_fetch_pc", o_pc, 32'h100);

        // Redirect while done and stalled: target wins over hold and pc+4.
        step(0, 1, 1, 32'h2000, 1); chk("brdone_still_done", 32'(o_done), 32'd1);
        step(0, 0, 0, 32'd0, 1);
        chk("brdone_done", 32'(o_done), 32'd0); chk("brdone_pc", o_pc, 32'h2000);
        chk("brdone_addr", o_addr, 32'h2000); chk("brdone_req", 32'(o_req), 32'd1);

        // Reset mid-fetch with two bytes received from 0x300.
        step(0, 0, 1, 32'h300, 1);
        step(0, 0, 0, 32'd0, 1);
        step(0, 0, 0, 32'd0, 1);
        step(0, 0, 0, 32'd0, 1);
        step(1, 0, 0, 32'd0, 1);
        step(1, 0, 0, 32'd0, 1);
        chk("rst_done", 32'(o_done), 32'd0); chk("rst_req", 32'(o_req), 32'd0); chk("rst_pc", o_pc, RESET_PC);
        step(0, 0, 0, 32'd0, 1); chk("rst_restart_addr", o_addr, RESET_PC); chk("rst_restart_req", 32'(o_req), 32'd1);
        step(0, 0, 0, 32'd0, 1);
        step(0, 0, 0, 32'd0, 1);
        step(0, 0, 0, 32'd0, 1);
        step(0, 0, 0, 32'd0, 1);
        step(0, 1, 0, 32'd0, 1);
        chk("rst_refetch_inst", o_inst, 32'h00a00513); chk("rst_refetch_done", 32'(o_done), 32'd1);

        // Fetch at the top of the address space, then pc+4 wraps to 0.
        step(0, 0, 1, 32'hFFFF_FFFE, 1);
        step(0, 0, 0, 32'd0, 1); chk("wrap_addr_first", o_addr, 32'hFFFF_FFFC);
        step(0, 0, 0, 32'd0, 1);
        step(0, 0, 0, 32'd0, 1);
        step(0, 0, 0, 32'd0, 1); chk("wrap_addr_last", o_addr, 32'hFFFF_FFFF);
        step(0, 0, 0, 32'd0, 1);
        step(0, 0, 0, 32'd0, 1); chk("wrap_done", 32'(o_done), 32'd1);
        step(0, 0, 0, 32'd0, 1); chk("wrap_next_addr", o_addr, 32'd0); chk("wrap_next_pc", o_pc, 32'd0);

        // Randomized traffic checked only against the model.
        for (int i = 0; i < 3000; i++) begin
            tgt = $urandom;
            if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 | (tgt & 32'hF);
            step($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 24) == 0, tgt, $urandom_range(0, 3) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
